// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller.
// master: pipeline/cache side. It drives the cache responses and the stage hazard info,
//         and it receives the enables, flushes, gated strobes and counters.
// slave : hazard_ctrl. It consumes the hazard info and drives the controls.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned REG_W = 5;

  // I-cache side
  logic             imem_resp;
  logic [31:0]      imem_rdata;
  logic             imem_read;
  logic [31:0]      instr_IF;

  // D-cache side
  logic             dmem_req;
  logic             dmem_resp;
  logic [31:0]      dmem_rdata;
  logic             dmem_go;
  logic [31:0]      rdata_MEM;

  // Hazard information from EX/ID
  logic             load_EX;
  logic [REG_W-1:0] rd_EX;
  logic [REG_W-1:0] rs1_ID;
  logic [REG_W-1:0] rs2_ID;
  logic             use_rs1_ID;
  logic             use_rs2_ID;
  logic             redirect_EX;

  // Stage controls
  logic             load_pc;
  logic             load_IF_ID;
  logic             load_ID_EX;
  logic             load_EX_MEM;
  logic             load_MEM_WB;
  logic             flush_IF_ID;
  logic             flush_ID_EX;

  // Event counters
  logic [CNT_W-1:0] cnt_dstall;
  logic [CNT_W-1:0] cnt_lu;
  logic [CNT_W-1:0] cnt_redirect;

  modport master (
    output imem_resp, imem_rdata, dmem_req, dmem_resp, dmem_rdata,
           load_EX, rd_EX, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, redirect_EX,
    input  imem_read, instr_IF, dmem_go, rdata_MEM,
           load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
           flush_IF_ID, flush_ID_EX, cnt_dstall, cnt_lu, cnt_redirect
  );

  modport slave (
    input  imem_resp, imem_rdata, dmem_req, dmem_resp, dmem_rdata,
           load_EX, rd_EX, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, redirect_EX,
    output imem_read, instr_IF, dmem_go, rdata_MEM,
           load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
           flush_IF_ID, flush_ID_EX, cnt_dstall, cnt_lu, cnt_redirect
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// It arbitrates four stall causes into per-stage load enables and bubble flushes:
// D-cache wait, redirect during an I-cache miss, load-use, and I-cache wait.
// Skid registers hold cache responses that arrive while the consuming stage is frozen.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        hazard_ctrl_if.slave
//              inputs : cache responses/data, EX/ID hazard info
//              outputs: enables, flushes, gated cache strobes, presented data, counters
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    SEL_RUN,
    SEL_DSTALL,
    SEL_RWAIT,
    SEL_REDIR,
    SEL_LU,
    SEL_FETCH
  } sel_e;

  logic             ihold_valid_q, ihold_valid_d;
  logic [31:0]      ihold_q, ihold_d;
  logic             dhold_valid_q, dhold_valid_d;
  logic [31:0]      dhold_q, dhold_d;
  logic             rwait_q, rwait_d;
  logic [CNT_W-1:0] cnt_dstall_q, cnt_dstall_d;
  logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d;
  logic [CNT_W-1:0] cnt_redirect_q, cnt_redirect_d;

  logic ifetch_ok;
  logic dmem_ok;
  logic fetch_pend;
  logic lu;
  sel_e sel;
  logic inc_redir;

  // Hazard terms and priority selection of the active case
  always_comb begin
    ifetch_ok  = ihold_valid_q | bus.imem_resp;
    dmem_ok    = !bus.dmem_req | dhold_valid_q | bus.dmem_resp;
    fetch_pend = !ihold_valid_q & !bus.imem_resp;
    lu         = bus.load_EX & (bus.rd_EX != '0) &
                 ((bus.use_rs1_ID & (bus.rs1_ID == bus.rd_EX)) |
                  (bus.use_rs2_ID & (bus.rs2_ID == bus.rd_EX)));
    sel = SEL_RUN;
    if (!dmem_ok)                       sel = SEL_DSTALL;
    else if (bus.redirect_EX && fetch_pend) sel = SEL_RWAIT;
    else if (bus.redirect_EX)           sel = SEL_REDIR;
    else if (lu)                        sel = SEL_LU;
    else if (!ifetch_ok)                sel = SEL_FETCH;
  end

  // Stage enables and flushes; everything is held off while in reset
  always_comb begin
    bus.load_pc     = 1'b0;
    bus.load_IF_ID  = 1'b0;
    bus.load_ID_EX  = 1'b0;
    bus.load_EX_MEM = 1'b0;
    bus.load_MEM_WB = 1'b0;
    bus.flush_IF_ID = 1'b0;
    bus.flush_ID_EX = 1'b0;
    if (!rst) begin
      unique case (sel)
        SEL_DSTALL, SEL_RWAIT: ;
        SEL_REDIR: begin
          bus.load_pc     = 1'b1;
          bus.load_IF_ID  = 1'b1;
          bus.load_ID_EX  = 1'b1;
          bus.load_EX_MEM = 1'b1;
          bus.load_MEM_WB = 1'b1;
          bus.flush_IF_ID = 1'b1;
          bus.flush_ID_EX = 1'b1;
        end
        SEL_LU: begin
          bus.load_ID_EX  = 1'b1;
          bus.load_EX_MEM = 1'b1;
          bus.load_MEM_WB = 1'b1;
          bus.flush_ID_EX = 1'b1;
        end
        SEL_FETCH: begin
          bus.load_IF_ID  = 1'b1;
          bus.load_ID_EX  = 1'b1;
          bus.load_EX_MEM = 1'b1;
          bus.load_MEM_WB = 1'b1;
          bus.flush_IF_ID = 1'b1;
        end
        default: begin
          bus.load_pc     = 1'b1;
          bus.load_IF_ID  = 1'b1;
          bus.load_ID_EX  = 1'b1;
          bus.load_EX_MEM = 1'b1;
          bus.load_MEM_WB = 1'b1;
        end
      endcase
    end
  end

  // Data muxing and request gating: a held response suppresses a re-request
  always_comb begin
    bus.instr_IF  = ihold_valid_q ? ihold_q : bus.imem_rdata;
    bus.rdata_MEM = dhold_valid_q ? dhold_q : bus.dmem_rdata;
    bus.imem_read = !ihold_valid_q & !rst;
    bus.dmem_go   = bus.dmem_req & !dhold_valid_q & !rst;
  end

  // The first REDIRECT after a wait still has rwait set, so both paths count once
  assign inc_redir = (sel == SEL_REDIR) & (!rwait_q | rwait_q & (sel != SEL_RWAIT));

  // Next-state for skid registers, rwait and counters
  always_comb begin
    ihold_valid_d  = ihold_valid_q;
    ihold_d        = ihold_q;
    dhold_valid_d  = dhold_valid_q;
    dhold_d        = dhold_q;
    rwait_d        = (sel == SEL_RWAIT);
    cnt_dstall_d   = cnt_dstall_q;
    cnt_lu_d       = cnt_lu_q;
    cnt_redirect_d = cnt_redirect_q;

    // Any IF/ID advance retires the held entry, consumed or flushed
    if (bus.load_IF_ID) begin
      ihold_valid_d = 1'b0;
    end else if (bus.imem_resp && !ihold_valid_q) begin
      ihold_valid_d = 1'b1;
      ihold_d       = bus.imem_rdata;
    end

    if (bus.load_MEM_WB) begin
      dhold_valid_d = 1'b0;
    end else if (bus.dmem_resp && bus.dmem_req && !dhold_valid_q) begin
      dhold_valid_d = 1'b1;
      dhold_d       = bus.dmem_rdata;
    end

    if ((sel == SEL_DSTALL) && (cnt_dstall_q != '1)) cnt_dstall_d = cnt_dstall_q + CNT_W'(1);
    if ((sel == SEL_LU) && (cnt_lu_q != '1))         cnt_lu_d = cnt_lu_q + CNT_W'(1);
    if (inc_redir && (cnt_redirect_q != '1))         cnt_redirect_d = cnt_redirect_q + CNT_W'(1);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ihold_valid_q  <= 1'b0;
      ihold_q        <= '0;
      dhold_valid_q  <= 1'b0;
      dhold_q        <= '0;
      rwait_q        <= 1'b0;
      cnt_dstall_q   <= '0;
      cnt_lu_q       <= '0;
      cnt_redirect_q <= '0;
    end else begin
      ihold_valid_q  <= ihold_valid_d;
      ihold_q        <= ihold_d;
      dhold_valid_q  <= dhold_valid_d;
      dhold_q        <= dhold_d;
      rwait_q        <= rwait_d;
      cnt_dstall_q   <= cnt_dstall_d;
      cnt_lu_q       <= cnt_lu_d;
      cnt_redirect_q <= cnt_redirect_d;
    end
  end

  assign bus.cnt_dstall   = cnt_dstall_q;
  assign bus.cnt_lu       = cnt_lu_q;
  assign bus.cnt_redirect = cnt_redirect_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a table-driven reference model.
module tb_hazard_ctrl;
  localparam int unsigned CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  localparam int K_RUN = 0, K_DS = 1, K_RW = 2, K_RD = 3, K_LU = 4, K_FE = 5;

  // Expected {load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB, flush_IF_ID, flush_ID_EX}
  logic [6:0] exp_tab [6] = '{7'b11111_00, 7'b00000_00, 7'b00000_00,
                              7'b11111_11, 7'b00111_01, 7'b01111_10};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();
  hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(hif));

  int n_chk = 0;
  int n_pass = 0;

  // Reference state
  logic        m_ihv = 1'b0, m_dhv = 1'b0;
  logic [31:0] m_ih = '0, m_dh = '0;
  int          m_cd = 0, m_cl = 0, m_cr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic int model_kind();
    logic haz;
    haz = hif.load_EX && (hif.rd_EX != 0) &&
          ((hif.use_rs1_ID && hif.rs1_ID == hif.rd_EX) ||
           (hif.use_rs2_ID && hif.rs2_ID == hif.rd_EX));
    if (hif.dmem_req && !m_dhv && !hif.dmem_resp) return K_DS;
    if (hif.redirect_EX && !m_ihv && !hif.imem_resp) return K_RW;
    if (hif.redirect_EX) return K_RD;
    if (haz) return K_LU;
    if (!m_ihv && !hif.imem_resp) return K_FE;
    return K_RUN;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // One cycle: inputs already driven; check mid-cycle, then advance the model at the edge
  task automatic step();
    int k;
    logic [6:0] e;
    logic [6:0] got;
    #4;
    k = model_kind();
    e = rst ? 7'd0 : exp_tab[k];
    got = {hif.load_pc, hif.load_IF_ID, hif.load_ID_EX, hif.load_EX_MEM,
           hif.load_MEM_WB, hif.flush_IF_ID, hif.flush_ID_EX};
    chk("ctrl", 32'(got), 32'(e));
    chk("imem_read", 32'(hif.imem_read), 32'(!m_ihv && !rst));
    chk("dmem_go", 32'(hif.dmem_go), 32'(hif.dmem_req && !m_dhv && !rst));
    if (!rst) begin
      chk("instr_IF", hif.instr_IF, m_ihv ? m_ih : hif.imem_rdata);
      chk("rdata_MEM", hif.rdata_MEM, m_dhv ? m_dh : hif.dmem_rdata);
      chk("cnt_dstall", 32'(hif.cnt_dstall), 32'(m_cd));
      chk("cnt_lu", 32'(hif.cnt_lu), 32'(m_cl));
      chk("cnt_redirect", 32'(hif.cnt_redirect), 32'(m_cr));
    end
    @(posedge clk);
    if (rst) begin
      m_ihv = 1'b0; m_dhv = 1'b0; m_cd = 0; m_cl = 0; m_cr = 0;
    end else begin
      if (e[5]) m_ihv = 1'b0;
      else if (hif.imem_resp && !m_ihv) begin m_ihv = 1'b1; m_ih = hif.imem_rdata; end
      if (e[2]) m_dhv = 1'b0;
      else if (hif.dmem_resp && hif.dmem_req && !m_dhv) begin m_dhv = 1'b1; m_dh = hif.dmem_rdata; end
      if (k == K_DS) m_cd = sat_inc(m_cd);
      if (k == K_LU) m_cl = sat_inc(m_cl);
      if (k == K_RD) m_cr = sat_inc(m_cr);
    end
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0;
    hif.imem_resp = 1'b1;  hif.imem_rdata = $urandom;
    hif.dmem_req = 1'b0;   hif.dmem_resp = 1'b0; hif.dmem_rdata = $urandom;
    hif.load_EX = 1'b0;    hif.rd_EX = '0; hif.rs1_ID = '0; hif.rs2_ID = '0;
    hif.use_rs1_ID = 1'b0; hif.use_rs2_ID = 1'b0; hif.redirect_EX = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    step();
    step();
    set_idle();
    step();

    // Load-use: one bubble, then RUN once the load moves to MEM
    hif.load_EX = 1'b1; hif.rd_EX = 5'd5; hif.rs1_ID = 5'd5; hif.use_rs1_ID = 1'b1;
    step();
    chk("lu_cnt", 32'(hif.cnt_lu), 32'd1);
    hif.load_EX = 1'b0;
    step();
    chk("lu_next_pc", 32'(hif.load_pc), 32'd1);

    // Load to x0 never stalls
    hif.load_EX = 1'b1; hif.rd_EX = 5'd0; hif.rs1_ID = 5'd0;
    step();
    chk("x0_pc", 32'(hif.load_pc), 32'd1);
    chk("x0_cnt", 32'(hif.cnt_lu), 32'd1);
    set_idle();

    // D-cache miss for 4 cycles, then the response cycle advances
    hif.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("ds_cnt", 32'(hif.cnt_dstall), 32'd4);
    hif.dmem_resp = 1'b1;
    step();
    chk("ds_resp_wb", 32'(hif.load_MEM_WB), 32'd1);

    // I-cache response captured during a freeze
    hif.dmem_resp = 1'b0; hif.imem_resp = 1'b1; hif.imem_rdata = 32'h00A00093;
    step();
    hif.imem_resp = 1'b0; hif.imem_rdata = 32'h12345678;
    #1;
    chk("fz_imem_read", 32'(hif.imem_read), 32'd0);
    chk("fz_instr", hif.instr_IF, 32'h00A00093);
    step();
    hif.dmem_resp = 1'b1;
    step();
    set_idle();
    step();

    // Redirect on an I-cache miss with a D-cache response landing mid-freeze
    hif.redirect_EX = 1'b1; hif.imem_resp = 1'b0; hif.dmem_req = 1'b1;
    step();
    hif.dmem_resp = 1'b1; hif.dmem_rdata = 32'hDEADBEEF;
    step();
    hif.dmem_resp = 1'b0; hif.dmem_rdata = 32'h0;
    #1;
    chk("rw_dmem_go", 32'(hif.dmem_go), 32'd0);
    chk("rw_rdata", hif.rdata_MEM, 32'hDEADBEEF);
    step();
    hif.imem_resp = 1'b1;
    step();
    chk("rd_cnt", 32'(hif.cnt_redirect), 32'd1);
    set_idle();
    step();

    // Counter saturation, then reset in the middle of a miss
    hif.dmem_req = 1'b1; hif.imem_resp = 1'b1;
    for (int i = 0; i < (1 << CW) + 3; i++) step();
    chk("sat_cnt", 32'(hif.cnt_dstall), 32'(CMAX));
    rst = 1'b1;
    step();
    rst = 1'b0; hif.imem_resp = 1'b0;
    #1;
    chk("rst_cnt", 32'(hif.cnt_dstall), 32'd0);
    chk("rst_ihv", 32'(hif.imem_read), 32'd1);
    chk("rst_dhv", 32'(hif.dmem_go), 32'd1);
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 99) < 2);
      hif.imem_resp  = ($urandom_range(0, 99) < 60);
      hif.imem_rdata = $urandom;
      hif.dmem_req   = ($urandom_range(0, 99) < 50);
      hif.dmem_resp  = ($urandom_range(0, 99) < 40);
      hif.dmem_rdata = $urandom;
      hif.load_EX    = ($urandom_range(0, 99) < 40);
      hif.rd_EX      = 5'($urandom_range(0, 3));
      hif.rs1_ID     = 5'($urandom_range(0, 3));
      hif.rs2_ID     = 5'($urandom_range(0, 3));
      hif.use_rs1_ID = 1'($urandom_range(0, 1));
      hif.use_rs2_ID = 1'($urandom_range(0, 1));
      hif.redirect_EX = ($urandom_range(0, 99) < 20);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
